// File: rtl/fpu_pkg.sv
// Shared FPU definitions: controller states and IEEE-754 single-precision constants.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADDSUB,
    NORM,
    DONE
  } fsm_state_e;

endpackage

// File: rtl/fpu_unpack.sv
// Splits an IEEE-754 word into sign, exponent and mantissa with hidden bit.
// Denormals are flushed: any zero exponent reports the operand as zero.
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = fpu_pkg::EXP_W,
  parameter int unsigned MAN_W = fpu_pkg::MAN_W
) (
  input  logic [EXP_W+MAN_W:0] word_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       man_o,
  output logic                 is_zero_o,
  output logic                 is_special_o
);

  always_comb begin
    sign_o       = word_i[EXP_W+MAN_W];
    exp_o        = word_i[EXP_W+MAN_W-1:MAN_W];
    is_zero_o    = (exp_o == '0);
    is_special_o = (exp_o == EXP_MAX);
    man_o        = is_zero_o ? '0 : {1'b1, word_i[MAN_W-1:0]};
  end

endmodule

// File: rtl/fpu_sub_seq.sv
// Multicycle single-precision subtractor (result = a - b), truncating, with
// one-bit-per-cycle alignment and normalization behind a start/done handshake.
module fpu_sub_seq
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = fpu_pkg::EXP_W,
  parameter int unsigned MAN_W = fpu_pkg::MAN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result
);

  localparam int unsigned W = EXP_W + MAN_W + 1;
  localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAN_W + 1);
  localparam logic [EXP_W:0]   EXP_ONE   = (EXP_W + 1)'(1);
  localparam logic [EXP_W:0]   EXP_INF   = {1'b0, {EXP_W{1'b1}}};

  typedef logic [MAN_W+1:0] man_t;

  fsm_state_e       state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
  logic             sign_q, sign_d, add_q, add_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic [EXP_W-1:0] diff_q, diff_d;
  man_t             man_q, man_d, small_q, small_d;

  logic             a_sign, b_sign, a_zero, b_zero, a_spec, b_spec;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;
  logic             sb_eff, a_ge_b;
  man_t             sum;

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .word_i      (a_q),
    .sign_o      (a_sign),
    .exp_o       (a_exp),
    .man_o       (a_man),
    .is_zero_o   (a_zero),
    .is_special_o(a_spec)
  );

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .word_i      (b_q),
    .sign_o      (b_sign),
    .exp_o       (b_exp),
    .man_o       (b_man),
    .is_zero_o   (b_zero),
    .is_special_o(b_spec)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    sign_d   = sign_q;
    add_d    = add_q;
    exp_d    = exp_q;
    diff_d   = diff_q;
    man_d    = man_q;
    small_d  = small_q;

    sb_eff = ~b_sign;
    a_ge_b = (a_q[W-2:0] >= b_q[W-2:0]);
    sum    = add_q ? (man_q + small_q) : (man_q - small_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        state_d = DONE;
        if (a_spec || b_spec) begin
          result_d = QNAN;
        end else if (a_zero && b_zero) begin
          result_d = POS_ZERO;
        end else if (a_zero) begin
          result_d = {sb_eff, b_q[W-2:0]};
        end else if (b_zero) begin
          result_d = a_q;
        end else begin
          // magnitude ordering keeps the subtract path non-negative
          add_d   = (a_sign == sb_eff);
          state_d = ALIGN;
          if (a_ge_b) begin
            sign_d  = a_sign;
            exp_d   = {1'b0, a_exp};
            man_d   = {1'b0, a_man};
            small_d = {1'b0, b_man};
            diff_d  = a_exp - b_exp;
          end else begin
            sign_d  = sb_eff;
            exp_d   = {1'b0, b_exp};
            man_d   = {1'b0, b_man};
            small_d = {1'b0, a_man};
            diff_d  = b_exp - a_exp;
          end
        end
      end

      ALIGN: begin
        if (diff_q == '0) begin
          state_d = ADDSUB;
        end else if (diff_q >= ALIGN_LIM) begin
          small_d = '0;
          diff_d  = '0;
          state_d = ADDSUB;
        end else begin
          small_d = small_q >> 1;
          diff_d  = diff_q - 1'b1;
          if (diff_q == EXP_W'(1)) state_d = ADDSUB;
        end
      end

      ADDSUB: begin
        if (sum == '0) begin
          result_d = POS_ZERO;
          state_d  = DONE;
        end else begin
          man_d   = sum;
          state_d = NORM;
        end
      end

      NORM: begin
        if (man_q[MAN_W+1]) begin
          man_d = man_q >> 1;
          exp_d = exp_q + EXP_ONE;
          if (exp_q + EXP_ONE == EXP_INF) begin
            result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            state_d  = DONE;
          end
        end else if (!man_q[MAN_W]) begin
          if (exp_q == EXP_ONE) begin
            result_d = POS_ZERO;
            state_d  = DONE;
          end else begin
            man_d = man_q << 1;
            exp_d = exp_q - EXP_ONE;
          end
        end else begin
          result_d = {sign_q, exp_q[EXP_W-1:0], man_q[MAN_W-1:0]};
          state_d  = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      add_q    <= 1'b0;
      exp_q    <= '0;
      diff_q   <= '0;
      man_q    <= '0;
      small_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      add_q    <= add_d;
      exp_q    <= exp_d;
      diff_q   <= diff_d;
      man_q    <= man_d;
      small_q  <= small_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_fpu_sub_seq.sv
// Self-checking bench for fpu_sub_seq against a plain-arithmetic reference of a - b.
module tb_fpu_sub_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_sub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  // Reference: flush denormals, truncate the aligned smaller operand, truncate the result.
  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic        sx, sy, s;
    int unsigned ex, ey, mx, my, e, mb, ms, m, sh;
    sx = x[31];
    sy = ~y[31];
    ex = 32'(x[30:23]);
    ey = 32'(y[30:23]);
    if (ex == 255 || ey == 255) return 32'h7FC0_0000;
    if (ex == 0 && ey == 0) return 32'h0;
    if (ex == 0) return {sy, y[30:0]};
    if (ey == 0) return x;
    mx = 32'h0080_0000 | 32'(x[22:0]);
    my = 32'h0080_0000 | 32'(y[22:0]);
    if (x[30:0] >= y[30:0]) begin
      s = sx; e = ex; mb = mx; ms = my >> (ex - ey);
    end else begin
      s = sy; e = ey; mb = my; ms = mx >> (ey - ex);
    end
    m = (sx == sy) ? mb + ms : mb - ms;
    if (m == 0) return 32'h0;
    if (m >= 32'h0100_0000) begin
      m = m >> 1;
      e = e + 1;
      if (e == 255) return {s, 8'hFF, 23'h0};
    end
    sh = 0;
    while (m < 32'h0080_0000) begin
      m = m << 1;
      sh++;
    end
    if (sh >= e) return 32'h0;
    e = e - sh;
    return {s, e[7:0], m[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat,
                        output bit busy_ok, output bit timed_out);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1; busy_ok = 1'b1; timed_out = 1'b1; res = 32'h0;
    while (lat <= 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        res = result;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [0:13] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                               32'h7F80_0000, 32'h4B80_0000, 32'h4B00_0000, 32'h0000_0000,
                               32'h3F80_0000, 32'h7F7F_FFFF, 32'h0080_0000, 32'h0000_0001,
                               32'h3F80_0000, 32'hC040_0000};
    logic [31:0] tb_ [0:13] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'hBF80_0000,
                                32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                                32'h8000_0000, 32'hFF7F_FFFF, 32'h0080_0001, 32'h0000_0000,
                                32'h7FC0_0000, 32'h4040_0000};
    logic [31:0] te [0:13] = '{32'h4000_0000, 32'hBF00_0000, 32'h0000_0000, 32'h4000_0000,
                               32'h7FC0_0000, 32'h4B80_0000, 32'h4AFF_FFFE, 32'hBF80_0000,
                               32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000,
                               32'h7FC0_0000, 32'hC0C0_0000};
    bit          tsp [0:13] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    logic [31:0] res;
    int          lat;
    bit          bok, tmo;
    for (int unsigned i = 0; i < 14; i++) begin
      run_op(ta[i], tb_[i], res, lat, bok, tmo);
      checks++;
      if (tmo) begin
        errors++; $display("FAIL dir_timeout[%0d]: got no done expected done within 51", i);
      end
      checks++;
      if (res !== te[i]) begin
        errors++; $display("FAIL dir_result[%0d]: %h - %h got %h expected %h", i, ta[i], tb_[i], res, te[i]);
      end
      checks++;
      if (!bok) begin
        errors++; $display("FAIL dir_busy[%0d]: got busy low during op expected high", i);
      end
      if (tsp[i]) begin
        checks++;
        if (lat != 2) begin errors++; $display("FAIL dir_special_lat[%0d]: got %0d expected 2", i, lat); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int   n;
    bit   seen;
    @(negedge clk);
    a = 32'h4B00_0000; b = 32'h3F80_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    repeat (2) @(negedge clk);
    a = 32'h4040_0000; b = 32'h3F80_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 60; n++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL ignore_timeout: got no done expected done"); end
    checks++;
    if (result !== 32'h4AFF_FFFE) begin
      errors++; $display("FAIL ignore_result: got %h expected 4afffffe", result);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res;
    int          lat;
    bit          bok, tmo;
    @(negedge clk);
    a = 32'h4B00_0000; b = 32'h3F80_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected 00000000", result); end
    @(negedge clk);
    reset = 1'b1;
    run_op(32'h4B00_0000, 32'h3F80_0000, res, lat, bok, tmo);
    checks++;
    if (tmo || res !== 32'h4AFF_FFFE) begin
      errors++; $display("FAIL midreset_recover: got %h expected 4afffffe", res);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, x, y, exp_v;
    int          lat;
    bit          bok, tmo;
    for (int unsigned k = 0; k < 4; k++) begin
      x = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      y = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      exp_v = ref_sub(x, y);
      run_op(x, y, res, lat, bok, tmo);
      checks++;
      if (tmo || res !== exp_v) begin
        errors++; $display("FAIL b2b_result[%0d]: %h - %h got %h expected %h", k, x, y, res, exp_v);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL b2b_after_done[%0d]: got busy %b done %b expected 0 0", k, busy, done);
      end
      checks++;
      if (result !== exp_v) begin
        errors++; $display("FAIL b2b_hold[%0d]: got %h expected %h", k, result, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, res, exp_v;
    logic [7:0]  ea;
    int          eb, lat;
    bit          bok, tmo;
    for (int unsigned i = 0; i < 300; i++) begin
      ea = 8'($urandom_range(1, 254));
      x  = {1'($urandom), ea, 23'($urandom)};
      case ($urandom_range(0, 9))
        0: y = $urandom;
        1: y = {1'($urandom), ea, 23'($urandom)};
        2: y = x;
        3: y = x ^ 32'h8000_0000;
        4: begin
          eb = int'(ea) - int'($urandom_range(20, 30));
          if (eb < 1) eb = 1;
          y = {1'($urandom), 8'(eb), 23'($urandom)};
        end
        5: begin
          x = {1'($urandom), 8'h00, 23'($urandom)};
          y = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        6: y = x ^ 32'($urandom_range(1, 255));
        default: begin
          eb = int'(ea) + int'($urandom_range(0, 6)) - 3;
          if (eb < 1) eb = 1;
          if (eb > 254) eb = 254;
          y = {1'($urandom), 8'(eb), 23'($urandom)};
        end
      endcase
      exp_v = ref_sub(x, y);
      run_op(x, y, res, lat, bok, tmo);
      checks++;
      if (tmo || res !== exp_v) begin
        errors++; $display("FAIL rand_result[%0d]: %h - %h got %h expected %h", i, x, y, res, exp_v);
      end
      checks++;
      if (lat < 2 || lat > 51 || !bok) begin
        errors++; $display("FAIL rand_timing[%0d]: got latency %0d busy_ok %b expected 2..51 and 1", i, lat, bok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
